uart_tx_fifo_gen: RTL

- Parametrised UART transmitter with an integrated transmit FIFO. It is the successor to the fixed 8-bit UART TX path in the system.
- Data width, FIFO depth and prescale width are set at elaboration. Parity and 1/2 stop bits are selected at run time.
- Words are accepted on a valid/ready handshake, buffered, and serialised back-to-back on tx_out.
- Sits between the memory/AES datapath output and the UART line.

---
 rtl/uart_tx_fifo_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_gen.sv
// UART transmitter with an integrated transmit FIFO.
// Data width, FIFO depth and prescale width are set at elaboration; parity and stop bits are chosen per frame.
module uart_tx_fifo_gen #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRESC_W    = 6,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 parity_en,
  input  logic                 parity_type,
  input  logic                 stop2,
  input  logic [PRESC_W-1:0]   prescale,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [CW-1:0]        fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic [PRESC_W-1:0]   p_eff, p_lat, timer;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l, par_bit, stop2_l, stop_idx;
  logic                 bit_end, frame_end, out_bit;

  assign in_ready   = (count != CW'(FIFO_DEPTH));
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign p_eff      = (prescale == '0) ? PRESC_W'(1) : prescale;
  assign bit_end    = (timer == p_lat - PRESC_W'(1));
  assign frame_end  = (state == STOP) && bit_end && (stop_idx == stop2_l);
  // A pop happens either from IDLE or on the final stop cycle, giving back-to-back frames.
  assign pop        = (count != '0) && ((state == IDLE) || frame_end);
  assign tx_busy    = (state != IDLE);

  always_comb begin
    out_bit = 1'b1;
    case (state)
      START:   out_bit = 1'b0;
      DATA:    out_bit = shreg[0];
      PARITY:  out_bit = par_bit;
      default: out_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      p_lat    <= PRESC_W'(1);
      par_en_l <= 1'b0;
      par_bit  <= 1'b0;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      tx_out  <= out_bit;
      tx_done <= frame_end;
      if (pop) begin
        shreg    <= head;
        par_bit  <= (^head) ^ parity_type;
        par_en_l <= parity_en;
        stop2_l  <= stop2;
        p_lat    <= p_eff;
        timer    <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        state    <= START;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          timer <= timer + PRESC_W'(1);
        end else begin
          timer <= '0;
          case (state)
            START: state <= DATA;
            DATA: begin
              shreg <= shreg >> 1;
              if (bit_idx == BW'(DATA_BITS - 1)) begin
                bit_idx <= '0;
                state   <= par_en_l ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end
            PARITY: state <= STOP;
            STOP: begin
              if (stop_idx == stop2_l) state <= IDLE;
              else stop_idx <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
